fn_sw_arbiter: RTL and testbench

//   Shares one bitwise function unit among N_REQ requesters: AND when sel=1, XOR when sel=0.

---
 rtl/fn_sw_arbiter_if.sv | 29 ++
 rtl/fn_sw_arbiter.sv | 112 +++++++++++
 tb/tb_fn_sw_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fn_sw_arbiter_if.sv
// rtl/fn_sw_arbiter_if.sv - requester/consumer handshake bundle for fn_sw_arbiter
// master = requesters plus result consumer, slave = arbiter.
interface fn_sw_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_sel;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTH-1:0]       res_data;
  logic [IDW-1:0]         res_id;
  logic                   res_op;

  modport master (
    output req_valid, req_sel, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_op
  );

  modport slave (
    input  req_valid, req_sel, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, res_op
  );
endinterface

// File: rtl/fn_sw_arbiter.sv
// rtl/fn_sw_arbiter.sv - round-robin arbiter sharing one AND/XOR unit with a single-entry result register
// Optional FN_SW_PRIO_EN: requester 0 wins whenever valid; the others rotate via ptr.
module fn_sw_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input logic            clk,
  input logic            rst_n,
  fn_sw_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int SW  = IDW + 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [IDW-1:0]   res_id_q;
  logic             res_op_q;

  logic             can_load;
  logic             gnt_found;
  logic             xfer;
  logic [IDW-1:0]   gnt_idx;
  logic [SW-1:0]    scan_idx;
  logic [N_REQ-1:0] gnt_onehot;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             op_sel;

  assign can_load = (state_q == EMPTY) || bus.res_ready;
  assign xfer     = gnt_found && can_load;

  // Scan from ptr upward; scan_idx is one bit wider so the wrap is a single subtract.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
`ifdef FN_SW_PRIO_EN
    if (bus.req_valid[0]) begin
      gnt_found = 1'b1;
    end
`endif
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + SW'(k);
      if (scan_idx >= SW'(N_REQ)) begin
        scan_idx = scan_idx - SW'(N_REQ);
      end
      if (!gnt_found && bus.req_valid[scan_idx[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    gnt_onehot = '0;
    a_sel      = '0;
    b_sel      = '0;
    op_sel     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        gnt_onehot[i] = xfer && rst_n;
        a_sel         = bus.req_a[i*WIDTH +: WIDTH];
        b_sel         = bus.req_b[i*WIDTH +: WIDTH];
        op_sel        = bus.req_sel[i];
      end
    end
  end

  assign res_data_d = op_sel ? (a_sel & b_sel) : (a_sel ^ b_sel);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
`ifdef FN_SW_PRIO_EN
      if (gnt_idx == '0) begin
        ptr_d = ptr_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      ptr_q      <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
      res_op_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: if (xfer) state_q <= FULL;
        FULL:  if (!xfer && bus.res_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      ptr_q <= ptr_d;
      if (xfer) begin
        res_data_q <= res_data_d;
        res_id_q   <= gnt_idx;
        res_op_q   <= op_sel;
      end
    end
  end

  assign bus.req_ready = gnt_onehot;
  assign bus.res_valid = (state_q == FULL);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_op    = res_op_q;
endmodule

// File: tb/tb_fn_sw_arbiter.sv
// tb/tb_fn_sw_arbiter.sv - self-checking bench for fn_sw_arbiter with a behavioural model
module tb_fn_sw_arbiter;
  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  fn_sw_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

  fn_sw_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    return s ? (a & b) : (a ^ b);
  endfunction

  function automatic logic [W-1:0] op_a(input int i);
    return bus.req_a[i*W +: W];
  endfunction

  function automatic logic [W-1:0] op_b(input int i);
    return bus.req_b[i*W +: W];
  endfunction

  // Behavioural model: holds at most one result, and a rotating start index.
  bit           m_full;
  logic [W-1:0] m_data;
  int           m_id;
  bit           m_op;
  int           m_ptr;

  always @(negedge clk) begin
    int  g;
    bit  can_load;
    logic [N-1:0] exp_rdy;
    if (!rst_n) begin
      m_full = 0; m_data = '0; m_id = 0; m_op = 0; m_ptr = 0;
      chk("m_rst_ready", 32'(bus.req_ready), 0);
      chk("m_rst_valid", 32'(bus.res_valid), 0);
      chk("m_rst_data", 32'(bus.res_data), 0);
      chk("m_rst_id", 32'(bus.res_id), 0);
    end else begin
      can_load = !m_full || bus.res_ready;
      g = -1;
      if (can_load) begin
`ifdef FN_SW_PRIO_EN
        if (bus.req_valid[0]) g = 0;
`endif
        for (int k = 0; k < N && g < 0; k++) begin
          if (bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      chk("m_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("m_valid", 32'(bus.res_valid), 32'(m_full));
      if (m_full) begin
        chk("m_data", 32'(bus.res_data), 32'(m_data));
        chk("m_id", 32'(bus.res_id), m_id);
        chk("m_op", 32'(bus.res_op), 32'(m_op));
      end
      if (g >= 0) begin
        m_full = 1;
        m_data = fn(op_a(g), op_b(g), bus.req_sel[g]);
        m_id   = g;
        m_op   = bus.req_sel[g];
`ifdef FN_SW_PRIO_EN
        if (g != 0) m_ptr = (g + 1) % N;
`else
        m_ptr = (g + 1) % N;
`endif
      end else if (bus.res_ready) begin
        m_full = 0;
      end
    end
  end

  task automatic rand_ops();
    bus.req_a   = {$urandom, $urandom};
    bus.req_b   = {$urandom, $urandom};
    bus.req_sel = N'($urandom);
  endtask

  initial begin
    logic [N-1:0] last_rdy;
    logic [W-1:0] exp_d;

    // Reset held with all requesters valid.
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    rand_ops();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);

    // Release: grants rotate 0,1,2,3,0 with no idle cycle.
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("first_grant", 32'(bus.req_ready), 32'h1);
    exp_d = fn(op_a(0), op_b(0), bus.req_sel[0]);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
      chk("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      chk("rr_id", 32'(bus.res_id), k - 1);
      chk("rr_valid", 32'(bus.res_valid), 1);
      if (k == 1) chk("rr_data0", 32'(bus.res_data), 32'(exp_d));
    end

    // Requester 0 alone: AND then XOR.
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    bus.req_a[7:0] = 8'hF0;
    bus.req_b[7:0] = 8'h3C;
    bus.req_sel[0] = 1'b1;
    #1 chk("req0_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk); #1;
    bus.req_sel[0] = 1'b0;
    #1;
    chk("and_data", 32'(bus.res_data), 32'h30);
    chk("and_id", 32'(bus.res_id), 0);
    chk("and_op", 32'(bus.res_op), 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    #1;
    chk("xor_data", 32'(bus.res_data), 32'hCC);
    chk("xor_op", 32'(bus.res_op), 0);

    // Stall: ptr is 1, so requester 1 loads and is held for 5 cycles.
    @(posedge clk); #1;
    bus.req_valid = '1;
    bus.res_ready = 1'b0;
    rand_ops();
    exp_d = fn(op_a(1), op_b(1), bus.req_sel[1]);
    #1 chk("stall_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #2;
    for (int k = 0; k < 5; k++) begin
      chk("stall_ready", 32'(bus.req_ready), 0);
      chk("stall_id", 32'(bus.res_id), 1);
      chk("stall_data", 32'(bus.res_data), 32'(exp_d));
      @(posedge clk); #2;
    end
    bus.res_ready = 1'b1;
    #1;
    chk("drain_grant", 32'(bus.req_ready), 32'h4);
    chk("drain_valid", 32'(bus.res_valid), 1);
    @(posedge clk); #2;
    chk("drain_id", 32'(bus.res_id), 2);
    chk("drain_next", 32'(bus.req_ready), 32'h8);

    // Wrap past requester 3, then only 1 and 3 valid.
    @(posedge clk); #1;
    bus.req_valid = 4'b1010;
    #1;
    chk("wrap_id", 32'(bus.res_id), 3);
    chk("wrap_grant", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #2;
    chk("sparse_id1", 32'(bus.res_id), 1);
    chk("sparse_grant3", 32'(bus.req_ready), 32'h8);
    @(posedge clk); #2;
    chk("sparse_id3", 32'(bus.res_id), 3);
    chk("pre_async_valid", 32'(bus.res_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.res_valid), 0);
    chk("async_ready", 32'(bus.req_ready), 0);
    repeat (2) @(posedge clk);
    #1;

    // Requesters 0 and 2 continuously valid.
    rst_n = 1'b1;
    bus.req_valid = 4'b0101;
    #1 chk("pair_first", 32'(bus.req_ready), 32'h1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #2;
`ifdef FN_SW_PRIO_EN
      chk("pair_grant", 32'(bus.req_ready), 32'h1);
`else
      chk("pair_grant", 32'(bus.req_ready), (k % 2) ? 32'h4 : 32'h1);
`endif
    end
    @(posedge clk); #1;
    bus.req_valid = 4'b0100;
    #1 chk("drop0_grant", 32'(bus.req_ready), 32'h4);

    // Randomized traffic with legal requester holding behaviour.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      last_rdy = bus.req_ready;
      @(posedge clk); #1;
      if (c == 1000) rst_n = 1'b0;
      if (c == 1003) rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && !last_rdy[i]) begin
          if ($urandom_range(0, 3) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          bus.req_valid[i]       = ($urandom_range(0, 2) != 0);
          bus.req_a[i*W +: W]    = W'($urandom);
          bus.req_b[i*W +: W]    = W'($urandom);
          bus.req_sel[i]         = 1'($urandom);
        end
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
    end

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
